lfsr_seq_gen: RTL and testbench

Parametrised Fibonacci LFSR sequence generator with runtime seed load, zero-state lockup recovery and hardware period measurement. It generalises the fixed 4-bit maximal-length LFSR to any width and tap set. It sits in the LFSR library as the common pseudo-random source for scramblers, PRBS test patterns and pseudo-random counters.

---
 rtl/lfsr_seq_gen.sv | 115 +++++++++++
 tb/tb_lfsr_seq_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_gen.sv
// lfsr_seq_gen
//   Parametrised Fibonacci LFSR with runtime seed load, zero-state lockup
//   recovery and hardware period measurement.
//
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   en        in   advance the LFSR one step per clock
//   load      in   load seed this cycle (priority over en)
//   seed      in   [WIDTH]  seed value sampled when load=1
//   state     out  [WIDTH]  current LFSR register
//   out_bit   out  serial output, state[WIDTH-1]
//   fb_bit    out  feedback of the current state, ^(state & TAPS)
//   wrap      out  one-cycle pulse when a step returns state to the reference seed
//   lockup    out  one-cycle pulse on rejected zero seed or zero-state recovery
//   step_cnt  out  [WIDTH]  steps since last load, reset or wrap
//   period    out  [WIDTH]  sequence length captured at the last wrap
module lfsr_seq_gen #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS       = 4'b1100,
  parameter logic [WIDTH-1:0] RESET_SEED = 4'b1001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state,
  output logic             out_bit,
  output logic             fb_bit,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] step_cnt,
  output logic [WIDTH-1:0] period
);

  logic [WIDTH-1:0] state_q,    state_d;
  logic [WIDTH-1:0] ref_seed_q, ref_seed_d;
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] period_q,   period_d;
  logic             wrap_q,     wrap_d;
  logic             lockup_q,   lockup_d;

  logic             fb;
  logic [WIDTH-1:0] state_next;

  assign fb         = ^(state_q & TAPS);
  assign state_next = {state_q[WIDTH-2:0], fb};

  always_comb begin
    state_d    = state_q;
    ref_seed_d = ref_seed_q;
    step_cnt_d = step_cnt_q;
    period_d   = period_q;
    wrap_d     = 1'b0;
    lockup_d   = 1'b0;

    if (load) begin
      // A zero seed would lock the register; substitute the reset seed.
      if (seed != '0) begin
        state_d    = seed;
        ref_seed_d = seed;
      end else begin
        state_d    = RESET_SEED;
        ref_seed_d = RESET_SEED;
        lockup_d   = 1'b1;
      end
      step_cnt_d = '0;
      period_d   = '0;
    end else if (en) begin
      if (state_q == '0) begin
        // Only reachable with a degenerate tap set; recover without a wrap.
        state_d    = RESET_SEED;
        lockup_d   = 1'b1;
        step_cnt_d = '0;
      end else begin
        state_d = state_next;
        if (state_next == ref_seed_q) begin
          wrap_d     = 1'b1;
          period_d   = step_cnt_q + WIDTH'(1);
          step_cnt_d = '0;
        end else begin
          step_cnt_d = step_cnt_q + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_SEED;
      ref_seed_q <= RESET_SEED;
      step_cnt_q <= '0;
      period_q   <= '0;
      wrap_q     <= 1'b0;
      lockup_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_seed_q <= ref_seed_d;
      step_cnt_q <= step_cnt_d;
      period_q   <= period_d;
      wrap_q     <= wrap_d;
      lockup_q   <= lockup_d;
    end
  end

  assign state    = state_q;
  assign out_bit  = state_q[WIDTH-1];
  assign fb_bit   = fb;
  assign wrap     = wrap_q;
  assign lockup   = lockup_q;
  assign step_cnt = step_cnt_q;
  assign period   = period_q;

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Bench for lfsr_seq_gen: a 4-bit default instance and an 8-bit instance.
// Drivers push hand-derived expectations into queues at the negedge that
// sets up each clock edge; monitors pop and compare just after the edge.
module tb_lfsr_seq_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, load;
  logic [3:0] seed;
  logic [3:0] state, step_cnt, period;
  logic       out_bit, fb_bit, wrap, lockup;

  logic       en8, load8;
  logic [7:0] seed8;
  logic [7:0] state8, step_cnt8, period8;
  logic       out_bit8, fb_bit8, wrap8, lockup8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_seq_gen dut4 (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed(seed),
    .state(state), .out_bit(out_bit), .fb_bit(fb_bit), .wrap(wrap),
    .lockup(lockup), .step_cnt(step_cnt), .period(period)
  );

  lfsr_seq_gen #(.WIDTH(8), .TAPS(8'b10111000), .RESET_SEED(8'h01)) dut8 (
    .clk(clk), .reset_n(reset_n), .en(en8), .load(load8), .seed(seed8),
    .state(state8), .out_bit(out_bit8), .fb_bit(fb_bit8), .wrap(wrap8),
    .lockup(lockup8), .step_cnt(step_cnt8), .period(period8)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       wr;
    logic       lk;
    logic [3:0] sc;
    logic [3:0] pd;
  } exp4_t;

  typedef struct packed {
    logic       known;
    logic       uq;
    logic [7:0] st;
    logic       wr;
    logic [7:0] sc;
    logic [7:0] pd;
  } exp8_t;

  exp4_t q4[$];
  exp8_t q8[$];
  exp4_t e4;
  exp8_t e8;
  bit    seen[256];

  // Hand-computed x^4+x^3+1 sequence starting from 1001.
  logic [3:0] seq [15] = '{4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                           4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110,
                           4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
  // Hand-computed first steps of the 8-bit sequence from 0x01.
  logic [7:0] seq8 [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic cyc4(input logic ld, input logic e, input logic [3:0] sd,
                      input logic [3:0] st, input logic wr, input logic lk,
                      input logic [3:0] sc, input logic [3:0] pd);
    @(negedge clk);
    load = ld; en = e; seed = sd;
    q4.push_back('{st: st, wr: wr, lk: lk, sc: sc, pd: pd});
  endtask

  task automatic cyc8(input logic e, input logic known, input logic uq,
                      input logic [7:0] st, input logic wr,
                      input logic [7:0] sc, input logic [7:0] pd);
    @(negedge clk);
    load8 = 1'b0; en8 = e; seed8 = '0;
    q8.push_back('{known: known, uq: uq, st: st, wr: wr, sc: sc, pd: pd});
  endtask

  always @(posedge clk) begin
    #1;
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      chk("state4",    {28'd0, state},    {28'd0, e4.st});
      chk("wrap4",     {31'd0, wrap},     {31'd0, e4.wr});
      chk("lockup4",   {31'd0, lockup},   {31'd0, e4.lk});
      chk("step_cnt4", {28'd0, step_cnt}, {28'd0, e4.sc});
      chk("period4",   {28'd0, period},   {28'd0, e4.pd});
      chk("out_bit4",  {31'd0, out_bit},  {31'd0, e4.st[3]});
      chk("fb_bit4",   {31'd0, fb_bit},   {31'd0, e4.st[3] ^ e4.st[2]});
    end
    if (q8.size() > 0) begin
      e8 = q8.pop_front();
      if (e8.known) chk("state8", {24'd0, state8}, {24'd0, e8.st});
      if (e8.uq) begin
        chk("nonzero8", {31'd0, (state8 == 8'h00)}, 32'd0);
        chk("unique8",  {31'd0, seen[state8]},      32'd0);
        seen[state8] = 1'b1;
      end
      chk("wrap8",     {31'd0, wrap8},     {31'd0, e8.wr});
      chk("lockup8",   {31'd0, lockup8},   32'd0);
      chk("step_cnt8", {24'd0, step_cnt8}, {24'd0, e8.sc});
      chk("period8",   {24'd0, period8},   {24'd0, e8.pd});
    end
  end

  initial begin
    reset_n = 1'b0; en = 1'b0; load = 1'b0; seed = '0;
    en8 = 1'b0; load8 = 1'b0; seed8 = '0;
    #12;
    chk("rst_state",  {28'd0, state},    32'h9);
    chk("rst_step",   {28'd0, step_cnt}, 32'd0);
    chk("rst_period", {28'd0, period},   32'd0);
    chk("rst_wrap",   {31'd0, wrap},     32'd0);
    chk("rst_lockup", {31'd0, lockup},   32'd0);
    chk("rst_state8", {24'd0, state8},   32'h01);
    @(negedge clk);
    reset_n = 1'b1;

    // Full period from the reset seed.
    for (int k = 1; k <= 15; k++)
      cyc4(0, 1, 4'h0, seq[k % 15], k == 15, 0, 4'(k % 15), (k == 15) ? 4'd15 : 4'd0);

    // Load 1101 with en also high: loads, does not step.
    cyc4(1, 1, 4'hD, 4'hD, 0, 0, 4'd0, 4'd0);
    cyc4(1, 1, 4'hD, 4'hD, 0, 0, 4'd0, 4'd0);
    for (int k = 1; k <= 15; k++)
      cyc4(0, 1, 4'h0, seq[(3 + k) % 15], k == 15, 0, 4'(k % 15), (k == 15) ? 4'd15 : 4'd0);

    // Zero seed rejected; reference falls back to 1001.
    cyc4(1, 0, 4'h0, 4'h9, 0, 1, 4'd0, 4'd0);
    for (int k = 1; k <= 14; k++)
      cyc4(0, 1, 4'h0, seq[k], 0, 0, 4'(k), 4'd0);
    cyc4(0, 1, 4'h0, seq[0], 1, 0, 4'd0, 4'd15);

    // Freeze for 5 cycles mid-sequence; wrap arrives 5 clocks later.
    for (int k = 1; k <= 5; k++)
      cyc4(0, 1, 4'h0, seq[k], 0, 0, 4'(k), 4'd15);
    for (int k = 0; k < 5; k++)
      cyc4(0, 0, 4'h0, seq[5], 0, 0, 4'd5, 4'd15);
    for (int k = 6; k <= 15; k++)
      cyc4(0, 1, 4'h0, seq[k % 15], k == 15, 0, 4'(k % 15), 4'd15);

    // Reach 0110, then pulse reset between edges.
    cyc4(0, 1, 4'h0, seq[1], 0, 0, 4'd1, 4'd15);
    cyc4(0, 1, 4'h0, seq[2], 0, 0, 4'd2, 4'd15);
    cyc4(0, 0, 4'h0, seq[2], 0, 0, 4'd2, 4'd15);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_state",  {28'd0, state},    32'h9);
    chk("async_step",   {28'd0, step_cnt}, 32'd0);
    chk("async_period", {28'd0, period},   32'd0);
    chk("async_wrap",   {31'd0, wrap},     32'd0);
    #1;
    reset_n = 1'b1;
    for (int k = 1; k <= 15; k++)
      cyc4(0, 1, 4'h0, seq[k % 15], k == 15, 0, 4'(k % 15), (k == 15) ? 4'd15 : 4'd0);
    cyc4(0, 0, 4'h0, seq[0], 0, 0, 4'd0, 4'd15);

    // 8-bit maximal sequence from reset.
    seen[8'h01] = 1'b1;
    for (int k = 1; k <= 255; k++)
      cyc8(1, (k <= 6) || (k == 255), k < 255,
           (k <= 6) ? seq8[k] : 8'h01, k == 255, 8'(k % 255),
           (k == 255) ? 8'd255 : 8'd0);
    cyc8(0, 1, 0, 8'h01, 0, 8'd0, 8'd255);

    for (int i = 0; i < 20 && (q4.size() > 0 || q8.size() > 0); i++)
      @(posedge clk);
    #2;
    chk("drain_q4", q4.size(), 32'd0);
    chk("drain_q8", q8.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
